// File: rtl/mem_arb_types.sv
// Shared types for the fetch/data single-port memory arbiter.
// Holds the arbiter FSM encoding and the owner tag of the access in flight.
package mem_arb_types;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/arb_fairness_ctr.sv
// Grant decision for the arbiter: data first, but a fetch that has watched
// MAX_DATA_BURST consecutive data grants wins the next arbitration.
module arb_fairness_ctr
    import mem_arb_types::*;
#(
    parameter int MAX_DATA_BURST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic dm_req,
    input  logic grant_en,
    output logic grant_if,
    output logic grant_dm
);

    localparam int CW = $clog2(MAX_DATA_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_DATA_BURST);

    logic [CW-1:0] starve_cnt;
    logic          fetch_due;

    always_comb begin
        fetch_due = (starve_cnt == BURST_MAX);
        grant_if  = 1'b0;
        grant_dm  = 1'b0;
        if (grant_en) begin
            if (dm_req && !(if_req && fetch_due)) begin
                grant_dm = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    // Counts data grants that a waiting fetch had to watch go by.
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_dm) begin
            if (!if_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != BURST_MAX) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between the CPU fetch and data ports.
// Every output is a register or a decode of registered state.
module mem_port_arbiter
    import mem_arb_types::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int RD_LAT         = 1,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rdy,
    output logic [15:0]       if_data,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_rdy,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    // Handshake: a requester holds req (with stable address/data) until its
    // rdy pulses for exactly one cycle; read data is valid in that cycle only.

    localparam int LW = $clog2(RD_LAT + 1);
    localparam logic [LW-1:0] LAT_LOAD = LW'(RD_LAT);

    arb_state_t        state;
    arb_state_t        state_nxt;
    arb_owner_t        owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [LW-1:0]     lat_cnt;
    logic              lat_done;
    logic [15:0]       if_data_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              grant_en;
    logic              grant_if;
    logic              grant_dm;

    arb_fairness_ctr #(
        .MAX_DATA_BURST(MAX_DATA_BURST)
    ) u_fairness (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .dm_req   (dm_req),
        .grant_en (grant_en),
        .grant_if (grant_if),
        .grant_dm (grant_dm)
    );

    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        lat_done  = (lat_cnt == LW'(1));
        unique case (state)
            ARB_IDLE: begin
                grant_en = 1'b1;
                if (grant_if || grant_dm) begin
                    state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                state_nxt = we_q ? ARB_RESP : ARB_WAIT;
            end
            ARB_WAIT: begin
                if (lat_done) begin
                    state_nxt = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_nxt = ARB_IDLE;
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            lat_cnt    <= '0;
            if_data_q  <= '0;
            dm_rdata_q <= '0;
        end else begin
            state <= state_nxt;

            // Fetches never write, so we_q alone marks a data write.
            if (grant_dm) begin
                owner_q <= OWN_DM;
                addr_q  <= dm_addr;
                wdata_q <= dm_wdata;
                we_q    <= dm_we;
            end else if (grant_if) begin
                owner_q <= OWN_IF;
                addr_q  <= if_addr;
                we_q    <= 1'b0;
            end

            if (state == ARB_ISSUE) begin
                lat_cnt <= LAT_LOAD;
            end else if (state == ARB_WAIT && !lat_done) begin
                lat_cnt <= lat_cnt - LW'(1);
            end

            if (state == ARB_WAIT && lat_done) begin
                if (owner_q == OWN_IF) begin
                    if_data_q <= ram_rdata[15:0];
                end else begin
                    dm_rdata_q <= ram_rdata;
                end
            end
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_we    = (state == ARB_ISSUE) && we_q;
    assign if_rdy    = (state == ARB_RESP) && (owner_q == OWN_IF);
    assign dm_rdy    = (state == ARB_RESP) && (owner_q == OWN_DM);
    assign busy      = (state != ARB_IDLE);
    assign if_data   = if_data_q;
    assign dm_rdata  = dm_rdata_q;

endmodule
